// File: rtl/cpu_seq_divider.sv
// ============================================================================
// Module      : cpu_seq_divider
// Description : Radix-2 restoring divider, one quotient bit per clock, for
//               div/divu. Optional macro CPU_DIV_ZERO_FAST_EN sends a zero
//               divisor straight to sign fix-up, skipping the iterations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_div_valid,
    output logic             E_div_ready,
    input  logic             E_div_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             kill,
    output logic             div_res_valid,
    input  logic             div_res_ready,
    output logic [WIDTH-1:0] div_quot,
    output logic [WIDTH-1:0] div_rem,
    output logic             div_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   src1_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               zero_q;
    logic [WIDTH-1:0]   quot_o_q;
    logic [WIDTH-1:0]   rem_o_q;
    logic               ready_q;
    logic               valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   mag1_d;
    logic [WIDTH-1:0]   mag2_d;
    logic [WIDTH:0]     rem_sh_d;
    logic               fits_d;
    logic [WIDTH-1:0]   iter_rem_d;
    logic [WIDTH-1:0]   iter_quot_d;
    logic [WIDTH-1:0]   fix_quot_d;
    logic [WIDTH-1:0]   fix_rem_d;

    // Most-negative input maps onto itself, which is the correct unsigned magnitude.
    assign mag1_d = (E_div_signed && E_src1[WIDTH-1]) ? -E_src1 : E_src1;
    assign mag2_d = (E_div_signed && E_src2[WIDTH-1]) ? -E_src2 : E_src2;

    // The shifted partial remainder needs one extra bit; the difference always fits WIDTH.
    assign rem_sh_d    = {rem_q, quot_q[WIDTH-1]};
    assign fits_d      = (rem_sh_d >= {1'b0, dvsr_q});
    assign iter_rem_d  = fits_d ? (rem_sh_d[WIDTH-1:0] - dvsr_q) : rem_sh_d[WIDTH-1:0];
    assign iter_quot_d = {quot_q[WIDTH-2:0], fits_d};

    assign fix_quot_d = zero_q ? {WIDTH{1'b1}} : (qneg_q ? -quot_q : quot_q);
    assign fix_rem_d  = zero_q ? src1_q        : (rneg_q ? -rem_q  : rem_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quot_o_q <= '0;
            rem_o_q  <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (E_div_valid && !kill) begin
                        src1_q  <= E_src1;
                        qneg_q  <= E_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
                        rneg_q  <= E_div_signed & E_src1[WIDTH-1];
                        zero_q  <= (E_src2 == '0);
                        rem_q   <= '0;
                        quot_q  <= mag1_d;
                        dvsr_q  <= mag2_d;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef CPU_DIV_ZERO_FAST_EN
                        state_q <= (E_src2 == '0) ? S_FIX : S_BUSY;
`else
                        state_q <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q  <= iter_rem_d;
                        quot_q <= iter_quot_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        quot_o_q <= fix_quot_d;
                        rem_o_q  <= fix_rem_d;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (kill || div_res_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign E_div_ready   = ready_q;
    assign div_res_valid = valid_q;
    assign div_busy      = busy_q;
    assign div_quot      = quot_o_q;
    assign div_rem       = rem_o_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq_divider.sv
// ============================================================================
// Module      : tb_cpu_seq_divider
// Description : Self-checking bench for cpu_seq_divider (table + random ops).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_div_valid = 1'b0;
    logic        E_div_ready;
    logic        E_div_signed = 1'b0;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        kill = 1'b0;
    logic        div_res_valid;
    logic        div_res_ready = 1'b0;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_busy;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .E_div_valid   (E_div_valid),
        .E_div_ready   (E_div_ready),
        .E_div_signed  (E_div_signed),
        .E_src1        (E_src1),
        .E_src2        (E_src2),
        .kill          (kill),
        .div_res_valid (div_res_valid),
        .div_res_ready (div_res_ready),
        .div_quot      (div_quot),
        .div_rem       (div_rem),
        .div_busy      (div_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef CPU_DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents the request and returns just after the accepting edge.
    task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!E_div_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("ready_timeout", 64'(E_div_ready), 64'd1);
        E_div_valid  = 1'b1;
        E_div_signed = sgn;
        E_src1       = a;
        E_src2       = b;
        tick();
        E_div_valid  = 1'b0;
        E_div_signed = 1'($urandom);
        E_src1       = $urandom;
        E_src2       = $urandom;
    endtask

    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit release_res,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output logic ready_low);
        start(sgn, a, b);
        lat       = 1;
        ready_low = 1'b1;
        while (!div_res_valid && lat < 100) begin
            if (E_div_ready || !div_busy) ready_low = 1'b0;
            tick();
            lat++;
        end
        if (E_div_ready) ready_low = 1'b0;
        q = div_quot;
        r = div_rem;
        if (release_res) begin
            div_res_ready = 1'b1;
            tick();
            div_res_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] q, r, q0, r0;
        logic [63:0] m;
        logic        rl, stable, saw_valid;
        int          lat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[5] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
        vecs[6] = '{1'b1, 32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF00};
        vecs[7] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
        vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};

        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", 64'(E_div_ready),   64'd1);
        check("rst_valid", 64'(div_res_valid), 64'd0);
        check("rst_busy",  64'(div_busy),      64'd0);
        check("rst_quot",  64'(div_quot),      64'd0);
        check("rst_rem",   64'(div_rem),       64'd0);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, q, r, lat, rl);
            check($sformatf("vec%0d_quot", i), 64'(q),   64'(vecs[i].q));
            check($sformatf("vec%0d_rem", i),  64'(r),   64'(vecs[i].r));
            check($sformatf("vec%0d_lat", i),  64'(lat), 64'(exp_lat(vecs[i].b)));
            check($sformatf("vec%0d_rdy", i),  64'(rl),  64'd1);
        end

        // kill together with a request in IDLE must be ignored
        E_div_valid = 1'b1; kill = 1'b1; E_src1 = 32'd5; E_src2 = 32'd1;
        tick();
        E_div_valid = 1'b0; kill = 1'b0;
        check("idle_kill_ready", 64'(E_div_ready), 64'd1);
        check("idle_kill_busy",  64'(div_busy),    64'd0);

        // result held in DONE while the consumer stalls, then back-to-back ops
        do_op(1'b0, 32'd1000, 32'd33, 1'b0, q0, r0, lat, rl);
        check("hold_quot", 64'(q0), 64'd30);
        check("hold_rem",  64'(r0), 64'd10);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!div_res_valid || div_quot !== q0 || div_rem !== r0 || E_div_ready) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        div_res_ready = 1'b1;
        tick();
        div_res_ready = 1'b0;
        check("release_valid", 64'(div_res_valid), 64'd0);
        check("release_ready", 64'(E_div_ready),   64'd1);
        do_op(1'b1, 32'hFFFF_FC18, 32'd10, 1'b1, q, r, lat, rl);
        check("b2b_quot", 64'(q),   64'hFFFF_FF9C);
        check("b2b_rem",  64'(r),   64'd0);
        check("b2b_lat",  64'(lat), 64'd34);

        // kill in BUSY cycle 15 abandons the op; the next one completes normally
        start(1'b0, 32'd50, 32'd4);
        saw_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (div_res_valid) saw_valid = 1'b1;
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_ready", 64'(E_div_ready), 64'd1);
        check("kill_busy",  64'(div_busy),    64'd0);
        for (int i = 0; i < 25; i++) begin
            if (div_res_valid) saw_valid = 1'b1;
            tick();
        end
        check("kill_no_result", 64'(saw_valid), 64'd0);
        do_op(1'b0, 32'd9, 32'd3, 1'b1, q, r, lat, rl);
        check("after_kill_quot", 64'(q),   64'd3);
        check("after_kill_rem",  64'(r),   64'd0);
        check("after_kill_lat",  64'(lat), 64'd34);

        // kill in DONE drops the result
        do_op(1'b0, 32'd77, 32'd5, 1'b0, q, r, lat, rl);
        check("done_kill_quot", 64'(q), 64'd15);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("done_kill_valid", 64'(div_res_valid), 64'd0);
        check("done_kill_ready", 64'(E_div_ready),   64'd1);

        // reset in BUSY cycle 5 clears all outputs (div_quot holds 15 beforehand)
        start(1'b0, 32'd123, 32'd4);
        repeat (4) tick();
        reset = 1'b1; kill = 1'b1; div_res_ready = 1'b1;
        tick();
        reset = 1'b0; kill = 1'b0; div_res_ready = 1'b0;
        check("midrst_ready", 64'(E_div_ready),   64'd1);
        check("midrst_busy",  64'(div_busy),      64'd0);
        check("midrst_valid", 64'(div_res_valid), 64'd0);
        check("midrst_quot",  64'(div_quot),      64'd0);
        check("midrst_rem",   64'(div_rem),       64'd0);

        // randomized operations against the arithmetic reference
        for (int i = 0; i < 60; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            m = ref_div(s, a, b);
            do_op(s, a, b, 1'b1, q, r, lat, rl);
            check($sformatf("rnd%0d_quot s=%0d %0h/%0h", i, s, a, b), 64'(q), 64'(m[63:32]));
            check($sformatf("rnd%0d_rem s=%0d %0h/%0h", i, s, a, b),  64'(r), 64'(m[31:0]));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(b)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_seq_divider.md
Name: cpu_seq_divider

Overview:
- Multi-cycle integer divider for the Nios II core. It is the inverse-direction companion to the 16x16 partial-product multiplier cell in the M stage.
- Accepts one div/divu operation from the E stage and iterates one quotient bit per clock (radix-2, restoring).
- Returns quotient and remainder to the writeback mux over a valid/ready handshake.
- Owns its own operand and result registers; no DSP blocks are used.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- E_div_valid  in  1  operation request
- E_div_ready  out  1  divider can accept; high only in IDLE
- E_div_signed  in  1  1 = div (two's complement), 0 = divu
- E_src1  in  WIDTH  dividend
- E_src2  in  WIDTH  divisor
- kill  in  1  pipeline flush; abandons the in-flight operation
- div_res_valid  out  1  result available
- div_res_ready  in  1  consumer takes the result
- div_quot  out  WIDTH  quotient
- div_rem  out  WIDTH  remainder
- div_busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high, named reset; clock is named clk.
  - Reset forces IDLE and clears div_quot, div_rem, div_res_valid and div_busy to 0. E_div_ready is 1 in the first cycle after reset.
- States: IDLE, BUSY, FIX, DONE.
  - IDLE: E_div_ready=1. On E_div_valid, latch the signedness, raw src1 and a zero-divisor flag. Load the magnitudes |src1| and |src2| (the unsigned values when E_div_signed=0). Clear the counter and go to BUSY.
  - BUSY: one iteration per cycle:
    - Shift {rem,quot} left by 1.
    - trial = rem - divisor. If trial >= 0 (no borrow), rem = trial and the quot LSB = 1; otherwise the quot LSB = 0.
    - After exactly WIDTH BUSY cycles, go to FIX.
  - FIX: apply signs.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign (truncating division).
    - Zero divisor overrides: quot = all ones, rem = raw src1, for both signed and unsigned.
    - Register the results into div_quot/div_rem and go to DONE.
  - DONE: div_res_valid=1 and outputs are held stable.
    - On div_res_ready=1, go to IDLE; div_res_valid drops the next cycle.
    - No new request is accepted in the same cycle.
- Latency: div_res_valid rises WIDTH+2 clock edges after the accepting edge (34 for WIDTH=32). Throughput is one operation per WIDTH+3 cycles minimum.
- Overflow: signed most-negative / -1 gives quot = 0x8000_0000, rem = 0. This falls out of the magnitude path with no special case.
- Boundary conditions:
  - kill in BUSY or FIX: return to IDLE the next cycle; div_res_valid never asserts for that operation.
  - kill in DONE: drop the result and go to IDLE.
  - kill and E_div_valid together in IDLE: the request is ignored.
  - reset mid-operation: same as the reset values above; it overrides kill and handshake inputs.
  - Operand inputs are ignored outside IDLE; changing them mid-operation has no effect.
  - div_quot/div_rem are undefined-but-stable outside DONE; the consumer samples them only when div_res_valid=1.

Optional Feature:
- Macro: CPU_DIV_ZERO_FAST_EN
- Defined: a zero divisor detected in IDLE goes straight to FIX, skipping BUSY. div_res_valid rises 2 edges after acceptance; result values are unchanged.
- Undefined: a zero divisor runs the full WIDTH iterations. Latency is WIDTH+2 and the FIX override produces the same values.

Test Plan:
- divu 100 / 7 -> quot=14, rem=2; div_res_valid rises exactly 34 cycles after the accept edge; E_div_ready=0 throughout.
- div 0xFFFF_FFF9 (-7) / 2 -> quot=0xFFFF_FFFD (-3), rem=0xFFFF_FFFF (-1). Also div 7 / 0xFFFF_FFFE (-2) -> quot=0xFFFF_FFFD, rem=1.
- div 0x8000_0000 / 0xFFFF_FFFF -> quot=0x8000_0000, rem=0. divu of the same operands -> quot=0, rem=0x8000_0000.
- divu 0x1234 / 0 and div 0xFFFF_FF00 / 0 -> quot=0xFFFF_FFFF, rem=src1. Latency is 2 cycles with CPU_DIV_ZERO_FAST_EN and 34 without.
- Hold div_res_ready=0 for 10 cycles in DONE -> div_res_valid, div_quot and div_rem are stable. Raise ready -> IDLE the next cycle; back-to-back requests succeed.
- Assert kill at BUSY cycle 15, then issue divu 9/3 -> no result from the first op; second yields quot=3, rem=0. Assert reset at BUSY cycle 5 -> all outputs 0 the next cycle and E_div_ready=1.
